multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Multicycle MIPS-subset control unit. Sequences fetch, decode, execute, memory and writeback for one instruction at a time. Drives every datapath enable, including the 2-bit pc_we code consumed by the PC write-enable handler:
- 0 = hold
- 1 = unconditional write
- 2 = write iff ALU result bit0 = 1

Also counts retired instructions.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  in  1  rising-edge clock, single clock domain
reset  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26] from instruction register
funct  in  6  IR[5:0] from instruction register
mem_ready  in  1  memory handshake; 1 = access completes this cycle
pc_we  out  2  PC write code (0 hold / 1 write / 2 write-if-ALU-bit0)
pc_src  out  2  PC mux: 0 ALU (PC+4), 1 regA (JR), 2 jump target, 3 latched branch target
ir_we  out  1  instruction register load
mem_re  out  1  memory read request
mem_we  out  1  memory write request
iord  out  1  memory address: 0 PC, 1 ALUOut
reg_we  out  1  register file write
reg_dst  out  2  write reg: 0 rt, 1 rd, 2 $31
mem_to_reg  out  2  writeback data: 0 ALUOut, 1 MDR, 2 PC
alu_src_a  out  1  0 PC, 1 regA
alu_src_b  out  2  0 regB, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2
alu_op  out  3  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 NEQ (1 iff A!=B), 5 EQ
tgt_we  out  1  latch branch target (ALUOut) into target register
instr_count  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Outputs are registered (Moore, decoded from state). Async reset forces:
  - state = FETCH
  - instr_count = 0
  - every other output = 0
- Reset asserted mid-instruction aborts that instruction; no partial write survives after reset deasserts.
- FETCH:
  - mem_re=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - Waits while mem_ready=0, with all write enables 0.
  - In the cycle mem_ready=1: ir_we=1, pc_we=1, pc_src=0. Next state DECODE.
- DECODE (1 cycle):
  - alu_src_a=0, alu_src_b=3, alu_op=ADD, tgt_we=1.
  - Dispatch on opcode:
    - 0x00 with funct 0x20/0x22/0x2A -> EXEC_R
    - 0x00 with funct 0x08 -> JR
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x08 or 0x0E -> EXEC_I
    - 0x04 or 0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x03 -> JAL
    - anything else -> see Optional Feature.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op = ADD/SUB/SLT per funct. Next WB_R.
- WB_R: reg_we=1, reg_dst=1, mem_to_reg=0. Retires.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op = ADD (0x08) or XOR (0x0E). Next WB_I.
- WB_I: reg_we=1, reg_dst=0, mem_to_reg=0. Retires.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD. Next MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: mem_re=1, iord=1. Holds until mem_ready=1, then MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1. Retires.
- MEM_WRITE: mem_we=1, iord=1. Holds until mem_ready=1; retires in that cycle.
- BRANCH (1 cycle):
  - alu_src_a=1, alu_src_b=0, alu_op = EQ (0x04) or NEQ (0x05).
  - pc_we=2, pc_src=3. Retires whether taken or not.
- JUMP: pc_we=1, pc_src=2. Retires.
- JR: pc_we=1, pc_src=1. Retires.
- JAL: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, mem_to_reg=2 (PC already +4), all in one cycle. Retires.
- Retire:
  - Next state FETCH.
  - instr_count increments by 1 in the retire cycle; wraps modulo 2^CNT_WIDTH.
- pc_we is never 2 outside BRANCH.
- pc_we, reg_we and mem_we are never asserted while a wait state has mem_ready=0.
- Latency, assuming zero memory wait: R/I/SW/LW take 4/4/4/5 cycles; BRANCH, JUMP, JR, JAL take 3 cycles.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An undecoded opcode/funct in DECODE goes to HALT.
  - HALT: all enables 0, illegal_op output (1 bit, reset 0) = 1.
  - HALT exits only on reset. instr_count is not incremented.
- Not defined:
  - Undecoded instructions retire as NOP directly from DECODE (no writes, instr_count+1), next FETCH.
  - The illegal_op port is absent.

Test Plan:
- Reset asserted mid-MEM_READ with mem_ready=1 -> immediately state FETCH, all outputs 0, instr_count=0.
- ADD (opcode 0x00, funct 0x20), mem_ready=1 always -> pc_we=1 only in FETCH cycle; reg_we=1, reg_dst=1 in cycle 4; instr_count 0 -> 1.
- LW (0x23), mem_ready low for 3 cycles in MEM_READ -> mem_re held 4 cycles, reg_we/pc_we stay 0; MEM_WB asserts reg_we=1, mem_to_reg=1; total 8 cycles.
- BNE (0x05) then BEQ (0x04) -> BRANCH cycle shows pc_we=2, pc_src=3, alu_op=4 then 5; each retires in 3 cycles.
- JAL (0x03) -> cycle 3 shows pc_we=1, pc_src=2, reg_we=1, reg_dst=2, mem_to_reg=2; next state FETCH.
- Opcode 0x3F: with CTRL_ILLEGAL_TRAP_EN -> illegal_op=1, stuck for 10 cycles, instr_count unchanged. Without -> back to FETCH after DECODE, instr_count+1.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS-subset control FSM: registered Moore controls, mem_ready-qualified write strobes.
// Optional macro CTRL_ILLEGAL_TRAP_EN: undecoded instructions halt and raise illegal_op.
module multicycle_ctrl_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 mem_ready,
  output logic [1:0]           pc_we,
  output logic [1:0]           pc_src,
  output logic                 ir_we,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 reg_we,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_op,
  output logic                 tgt_we,
  output logic [CNT_WIDTH-1:0] instr_count
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_op
`endif
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_JUMP,
    S_JR,
    S_JAL,
    S_HALT
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;
  localparam logic [2:0] ALU_NEQ = 3'd4;
  localparam logic [2:0] ALU_EQ  = 3'd5;

  // fetch_req / wr_req mark states whose write strobes complete on mem_ready.
  typedef struct packed {
    logic [1:0] pc_we;
    logic [1:0] pc_src;
    logic       mem_re;
    logic       iord;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       tgt_we;
    logic       fetch_req;
    logic       wr_req;
  } ctrl_t;

  state_e               state_q, state_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 retire;

  // S_HALT doubles as the "undecoded" marker returned by the dispatcher.
  function automatic state_e dispatch(input logic [5:0] op, input logic [5:0] fn);
    state_e s;
    s = S_HALT;
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) s = S_EXEC_R;
        else if (fn == 6'h08) s = S_JR;
      end
      6'h23, 6'h2B: s = S_MEM_ADDR;
      6'h08, 6'h0E: s = S_EXEC_I;
      6'h04, 6'h05: s = S_BRANCH;
      6'h02:        s = S_JUMP;
      6'h03:        s = S_JAL;
      default:      s = S_HALT;
    endcase
    return s;
  endfunction

  function automatic ctrl_t ctrl_for(input state_e s, input logic [5:0] op,
                                     input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_re    = 1'b1;
        c.alu_src_b = 2'd1;
        c.alu_op    = ALU_ADD;
        c.fetch_req = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'd3;
        c.alu_op    = ALU_ADD;
        c.tgt_we    = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd0;
        c.alu_op    = (fn == 6'h22) ? ALU_SUB : (fn == 6'h2A) ? ALU_SLT : ALU_ADD;
      end
      S_WB_R: begin
        c.reg_we  = 1'b1;
        c.reg_dst = 2'd1;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.alu_op    = (op == 6'h0E) ? ALU_XOR : ALU_ADD;
      end
      S_WB_I: c.reg_we = 1'b1;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        c.mem_re = 1'b1;
        c.iord   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_we     = 1'b1;
        c.mem_to_reg = 2'd1;
      end
      S_MEM_WRITE: begin
        c.iord   = 1'b1;
        c.wr_req = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd0;
        c.alu_op    = (op == 6'h05) ? ALU_NEQ : ALU_EQ;
        c.pc_we     = 2'd2;
        c.pc_src    = 2'd3;
      end
      S_JUMP: begin
        c.pc_we  = 2'd1;
        c.pc_src = 2'd2;
      end
      S_JR: begin
        c.pc_we  = 2'd1;
        c.pc_src = 2'd1;
      end
      S_JAL: begin
        c.pc_we      = 2'd1;
        c.pc_src     = 2'd2;
        c.reg_we     = 1'b1;
        c.reg_dst    = 2'd2;
        c.mem_to_reg = 2'd2;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next state, retire detection; controls are decoded from the next state and registered.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: if (ctrl_q.fetch_req && mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = dispatch(opcode, funct);
`ifndef CTRL_ILLEGAL_TRAP_EN
        if (state_d == S_HALT) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
`endif
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (opcode == 6'h2B) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP, S_JR, S_JAL: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    ctrl_d = ctrl_for(state_d, opcode, funct);
    cnt_d  = retire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= (state_d == S_HALT);
  end

  assign illegal_op = illegal_q;
`endif

  // Strobes that complete a memory handshake only fire in the cycle mem_ready is high.
  assign ir_we       = ctrl_q.fetch_req & mem_ready;
  assign pc_we       = (ctrl_q.fetch_req & mem_ready) ? 2'd1 : ctrl_q.pc_we;
  assign mem_we      = ctrl_q.wr_req & mem_ready;
  assign pc_src      = ctrl_q.pc_src;
  assign mem_re      = ctrl_q.mem_re;
  assign iord        = ctrl_q.iord;
  assign reg_we      = ctrl_q.reg_we;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign alu_op      = ctrl_q.alu_op;
  assign tgt_we      = ctrl_q.tgt_we;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed and random instruction streams
// checked cycle by cycle against a per-instruction-class reference model.
module tb_multicycle_ctrl_fsm;

  localparam int CW = 4;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4;
  localparam int K_J = 5, K_JR = 6, K_JAL = 7, K_BAD = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic          mem_ready = 1'b0;
  logic [1:0]    pc_we, pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic          ir_we, mem_re, mem_we, iord, reg_we, alu_src_a, tgt_we;
  logic [2:0]    alu_op;
  logic [CW-1:0] instr_count;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic          illegal_op;
  logic          exp_ill = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt = 0;

  multicycle_ctrl_fsm #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_re(mem_re), .mem_we(mem_we),
    .iord(iord), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .tgt_we(tgt_we),
    .instr_count(instr_count)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {pc_we, pc_src, ir_we, mem_re, mem_we, iord, reg_we, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, tgt_we};

  function automatic logic [19:0] v(input int pw, input int ps, input int ir, input int mr,
                                    input int mw, input int io, input int rw, input int rd,
                                    input int mt, input int sa, input int sb, input int ao,
                                    input int tg);
    return {2'(pw), 2'(ps), 1'(ir), 1'(mr), 1'(mw), 1'(io), 1'(rw), 2'(rd), 2'(mt),
            1'(sa), 2'(sb), 3'(ao), 1'(tg)};
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) return K_R;
    if (op == 6'h00 && fn == 6'h08) return K_JR;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h08 || op == 6'h0E) return K_I;
    if (op == 6'h04 || op == 6'h05) return K_BR;
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
    return K_BAD;
  endfunction

  task automatic chk(input string tag, input logic [19:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s outputs=%h required=%h", tag, obs, exp);
    end
    n_tests++;
    assert (instr_count === CW'(model_cnt)) else begin
      n_fail++;
      $error("FAIL %s instr_count=%0d required=%0d", tag, instr_count, CW'(model_cnt));
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    n_tests++;
    assert (illegal_op === exp_ill) else begin
      n_fail++;
      $error("FAIL %s illegal_op=%b required=%b", tag, illegal_op, exp_ill);
    end
`endif
  endtask

  task automatic step(input string tag, input logic mr, input logic [19:0] exp);
    @(posedge clk);
    #2 mem_ready = mr;
    #1 chk(tag, exp);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Called just after a check point; asserts reset asynchronously, then releases it.
  task automatic do_reset(input string tag);
    mem_ready = 1'b1;
    reset = 1'b1;
    model_cnt = 0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    exp_ill = 1'b0;
`endif
    #1 chk({tag, "_in_reset"}, '0);
    @(posedge clk);
    #2 reset = 1'b0;
    mem_ready = 1'b1;
    #1 chk({tag, "_post_reset"}, '0);
  endtask

  task automatic fetch_phase(input int fw);
    for (int i = 0; i < fw; i++) step("fetch_wait", 1'b0, v(0,0,0,1,0,0,0,0,0,0,1,0,0));
    step("fetch", 1'b1, v(1,0,1,1,0,0,0,0,0,0,1,0,0));
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw);
    int k;
    k = classify(op, fn);
    fetch_phase(fw);
    opcode = op;
    funct  = fn;
    step("decode", rnd_bit(), v(0,0,0,0,0,0,0,0,0,0,3,0,1));
    case (k)
      K_R: begin
        step("exec_r", rnd_bit(),
             v(0,0,0,0,0,0,0,0,0,1,0,(fn == 6'h22) ? 1 : (fn == 6'h2A) ? 3 : 0,0));
        step("wb_r", rnd_bit(), v(0,0,0,0,0,0,1,1,0,0,0,0,0));
        model_cnt++;
      end
      K_I: begin
        step("exec_i", rnd_bit(), v(0,0,0,0,0,0,0,0,0,1,2,(op == 6'h0E) ? 2 : 0,0));
        step("wb_i", rnd_bit(), v(0,0,0,0,0,0,1,0,0,0,0,0,0));
        model_cnt++;
      end
      K_LW: begin
        step("lw_addr", rnd_bit(), v(0,0,0,0,0,0,0,0,0,1,2,0,0));
        for (int i = 0; i < mw; i++) step("lw_wait", 1'b0, v(0,0,0,1,0,1,0,0,0,0,0,0,0));
        step("lw_read", 1'b1, v(0,0,0,1,0,1,0,0,0,0,0,0,0));
        step("lw_wb", rnd_bit(), v(0,0,0,0,0,0,1,0,1,0,0,0,0));
        model_cnt++;
      end
      K_SW: begin
        step("sw_addr", rnd_bit(), v(0,0,0,0,0,0,0,0,0,1,2,0,0));
        for (int i = 0; i < mw; i++) step("sw_wait", 1'b0, v(0,0,0,0,0,1,0,0,0,0,0,0,0));
        step("sw_write", 1'b1, v(0,0,0,0,1,1,0,0,0,0,0,0,0));
        model_cnt++;
      end
      K_BR: begin
        step("branch", rnd_bit(), v(2,3,0,0,0,0,0,0,0,1,0,(op == 6'h05) ? 4 : 5,0));
        model_cnt++;
      end
      K_J: begin
        step("jump", rnd_bit(), v(1,2,0,0,0,0,0,0,0,0,0,0,0));
        model_cnt++;
      end
      K_JR: begin
        step("jr", rnd_bit(), v(1,1,0,0,0,0,0,0,0,0,0,0,0));
        model_cnt++;
      end
      K_JAL: begin
        step("jal", rnd_bit(), v(1,2,0,0,0,0,1,2,2,0,0,0,0));
        model_cnt++;
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
        for (int i = 0; i < 10; i++) step("halt", rnd_bit(), '0);
        do_reset("halt_exit");
`else
        model_cnt++;
`endif
      end
    endcase
  endtask

  logic [5:0] op_pool [14] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0E,
                               6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h01, 6'h00};
  logic [5:0] fn_pool [6]  = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h21, 6'h00};

  initial begin
    logic [5:0] op, fn;
    #3 do_reset("init");

    run_instr(6'h00, 6'h20, 0, 0);
    run_instr(6'h23, 6'h11, 0, 3);
    run_instr(6'h05, 6'h3C, 0, 0);
    run_instr(6'h04, 6'h01, 1, 0);
    run_instr(6'h03, 6'h15, 0, 0);
    run_instr(6'h3F, 6'h00, 0, 0);
    run_instr(6'h2B, 6'h07, 2, 2);
    run_instr(6'h00, 6'h08, 0, 0);
    run_instr(6'h08, 6'h2A, 0, 0);
    run_instr(6'h0E, 6'h22, 1, 0);
    run_instr(6'h00, 6'h22, 0, 0);
    run_instr(6'h00, 6'h2A, 0, 0);
    run_instr(6'h02, 6'h30, 0, 0);

    // Abort a load in the middle of its memory wait.
    fetch_phase(0);
    opcode = 6'h23;
    funct  = 6'h00;
    step("abort_decode", 1'b0, v(0,0,0,0,0,0,0,0,0,0,3,0,1));
    step("abort_addr", 1'b0, v(0,0,0,0,0,0,0,0,0,1,2,0,0));
    step("abort_wait", 1'b0, v(0,0,0,1,0,1,0,0,0,0,0,0,0));
    do_reset("abort");
    run_instr(6'h00, 6'h20, 0, 0);

    for (int n = 0; n < 45; n++) begin
      op = op_pool[$urandom_range(0, 13)];
      fn = (op == 6'h00) ? fn_pool[$urandom_range(0, 5)] : 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
